// File: rtl/hbmc_pkg.sv
// Shared types for the HyperBus read capture path: ISERDES ratio, capture FSM states
// and the beat-position/count type.
package hbmc_pkg;
  localparam int HBMC_ISERDES_RATIO = 6;

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, CAPTURE} hbmc_cap_state_t;

  typedef logic [2:0] hbmc_beat_pos_t;
endpackage

// File: rtl/hbmc_rwds_edge_det.sv
// RWDS edge detector: window {s[-1], s[0..5]} (bit 6 = s[-1]) to per-sample edge and
// rising-edge masks indexed by sample position k. Purely combinational.
module hbmc_rwds_edge_det
  import hbmc_pkg::*;
(
  input  logic [HBMC_ISERDES_RATIO:0]   window,
  output logic [HBMC_ISERDES_RATIO-1:0] edge_mask,
  output logic [HBMC_ISERDES_RATIO-1:0] rise_mask
);
  always_comb begin
    edge_mask = '0;
    rise_mask = '0;
    for (int k = 0; k < HBMC_ISERDES_RATIO; k++) begin
      // s[k] lives at window bit RATIO-1-k, s[k-1] one bit above it
      edge_mask[k] = window[HBMC_ISERDES_RATIO-1-k] ^ window[HBMC_ISERDES_RATIO-k];
      rise_mask[k] = window[HBMC_ISERDES_RATIO-1-k] & ~window[HBMC_ISERDES_RATIO-k];
    end
  end
endmodule

// File: rtl/hbmc_dq_capture.sv
// HyperBus read capture: RWDS-edge beat picking and 2-beat word assembly; word_valid one
// cycle after the sample cycle, no back-pressure. HBMC_DQ_CAPTURE_GLITCH_CHECK_EN rejects edges <2 samples apart.
module hbmc_dq_capture
  import hbmc_pkg::*;
#(
  parameter int DQ_WIDTH       = 8,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                                   iserdes_clkdiv,
  input  logic                                   arst,
  input  logic                                   start,
  input  logic [LEN_WIDTH-1:0]                   rd_len,
  input  logic [HBMC_ISERDES_RATIO*DQ_WIDTH-1:0] dq_samples,
  input  logic [HBMC_ISERDES_RATIO-1:0]          rwds_samples,
  output logic [2*DQ_WIDTH-1:0]                  word_data,
  output logic                                   word_valid,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeout,
  output logic                                   err
);
  localparam int R    = HBMC_ISERDES_RATIO;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  hbmc_cap_state_t            state, state_nxt;
  logic                       rwds_prev;
  logic                       carry, carry_nxt;
  logic                       pend_vld, pend_vld_nxt;
  logic [DQ_WIDTH-1:0]        pend_dat, pend_dat_nxt;
  logic [LEN_WIDTH-1:0]       remaining, remaining_nxt;
  logic [TO_W-1:0]            to_cnt, to_cnt_nxt;
  logic [2*DQ_WIDTH-1:0]      word_data_nxt;
  logic                       word_valid_nxt, done_nxt, timeout_nxt, err_nxt;

  logic [R-1:0]               edge_mask, rise_mask, glitch, acc;
  logic [R-1:0][DQ_WIDTH-1:0] samp;
  hbmc_beat_pos_t             nbeat;
  logic [DQ_WIDTH-1:0]        beat0, beat1;
  logic                       word_fire, last_word;

  hbmc_rwds_edge_det u_edge_det (
    .window   ({rwds_prev, rwds_samples}),
    .edge_mask(edge_mask),
    .rise_mask(rise_mask)
  );

`ifdef HBMC_DQ_CAPTURE_GLITCH_CHECK_EN
  logic edge5_prev;

  always_ff @(posedge iserdes_clkdiv or posedge arst) begin
    if (arst) edge5_prev <= 1'b0;
    else      edge5_prev <= edge_mask[R-1];
  end

  assign glitch = edge_mask & {edge_mask[R-2:0], edge5_prev};
`else
  assign glitch = '0;
`endif

  // Regroup lane-major ISERDES bits into one DQ_WIDTH-bit vector per sample slot
  always_comb begin
    samp = '0;
    for (int j = 0; j < R; j++)
      for (int i = 0; i < DQ_WIDTH; i++)
        samp[j][i] = dq_samples[R*i + R-1-j];
  end

  // While waiting, nothing counts until the first rising edge of the cycle
  always_comb begin : p_accept
    logic seen;
    seen = (state == CAPTURE);
    acc  = '0;
    for (int k = 0; k < R; k++) begin
      if (edge_mask[k] && !glitch[k]) begin
        if (rise_mask[k]) seen = 1'b1;
        acc[k] = seen && (state != IDLE);
      end
    end
  end

  // Carried beat from the previous cycle's k=5 edge goes first, then this cycle's edges
  always_comb begin
    nbeat = '0;
    beat0 = '0;
    beat1 = '0;
    if (carry) begin
      beat0 = samp[0];
      nbeat = 3'd1;
    end
    for (int k = 0; k < R-1; k++) begin
      if (acc[k]) begin
        if (nbeat == 3'd0)      beat0 = samp[k+1];
        else if (nbeat == 3'd1) beat1 = samp[k+1];
        nbeat = nbeat + 3'd1;
      end
    end
  end

  assign word_fire = pend_vld ? (nbeat != 3'd0) : (nbeat >= 3'd2);
  assign last_word = word_fire && (remaining == LEN_WIDTH'(1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    carry_nxt      = 1'b0;
    pend_vld_nxt   = pend_vld;
    pend_dat_nxt   = pend_dat;
    remaining_nxt  = remaining;
    to_cnt_nxt     = to_cnt;
    word_data_nxt  = word_data;
    word_valid_nxt = 1'b0;
    done_nxt       = 1'b0;
    timeout_nxt    = 1'b0;
    err_nxt        = err;
    case (state)
      IDLE: begin
        pend_vld_nxt = 1'b0;
        if (start) begin
          err_nxt       = 1'b0;
          to_cnt_nxt    = '0;
          remaining_nxt = rd_len;
          if (rd_len == '0) done_nxt  = 1'b1;
          else              state_nxt = WAIT_EDGE;
        end
      end
      default: begin
        carry_nxt = acc[R-1];
        if ((nbeat > 3'd2) || (|glitch)) err_nxt = 1'b1;
        if (|acc) state_nxt = CAPTURE;

        if (pend_vld) begin
          if (nbeat != 3'd0) begin
            word_data_nxt = {pend_dat, beat0};
            pend_vld_nxt  = (nbeat >= 3'd2);
            pend_dat_nxt  = beat1;
          end
        end else if (nbeat >= 3'd2) begin
          word_data_nxt = {beat0, beat1};
        end else if (nbeat == 3'd1) begin
          pend_vld_nxt = 1'b1;
          pend_dat_nxt = beat0;
        end
        if (word_fire) begin
          word_valid_nxt = 1'b1;
          remaining_nxt  = remaining - LEN_WIDTH'(1);
        end

        if (|edge_mask)            to_cnt_nxt  = '0;
        else if (to_cnt >= TO_LAST) timeout_nxt = !last_word;
        else                       to_cnt_nxt  = to_cnt + TO_W'(1);

        if (last_word || timeout_nxt) begin
          done_nxt     = last_word;
          state_nxt    = IDLE;
          pend_vld_nxt = 1'b0;
          carry_nxt    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge iserdes_clkdiv or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      rwds_prev  <= 1'b0;
      carry      <= 1'b0;
      pend_vld   <= 1'b0;
      pend_dat   <= '0;
      remaining  <= '0;
      to_cnt     <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      rwds_prev  <= rwds_samples[0];
      carry      <= carry_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_dat   <= pend_dat_nxt;
      remaining  <= remaining_nxt;
      to_cnt     <= to_cnt_nxt;
      word_data  <= word_data_nxt;
      word_valid <= word_valid_nxt;
      done       <= done_nxt;
      timeout    <= timeout_nxt;
      err        <= err_nxt;
    end
  end
endmodule

// File: tb/tb_hbmc_dq_capture.sv
// Directed bench for hbmc_dq_capture: hand-computed words and status per scenario.
module tb_hbmc_dq_capture;
  localparam int TO = 32;
  localparam logic [7:0] F = 8'hEE;

  logic        iserdes_clkdiv = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rd_len = '0;
  logic [47:0] dq_samples = '0;
  logic [5:0]  rwds_samples = '0;
  logic [15:0] word_data;
  logic        word_valid, busy, done, timeout, err;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [20:0] e;

  hbmc_dq_capture #(.DQ_WIDTH(8), .LEN_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .iserdes_clkdiv(iserdes_clkdiv),
    .arst          (arst),
    .start         (start),
    .rd_len        (rd_len),
    .dq_samples    (dq_samples),
    .rwds_samples  (rwds_samples),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .err           (err)
  );

  always #5 iserdes_clkdiv = ~iserdes_clkdiv;

  // Flags order {word_valid, done, busy, timeout, err}; data only matters when valid
  function automatic logic [20:0] ex(input logic [4:0] flags, input logic [15:0] d);
    return {flags, flags[4] ? d : 16'h0};
  endfunction

  function automatic logic [20:0] obs();
    return {word_valid, done, busy, timeout, err, word_valid ? word_data : 16'h0};
  endfunction

  function automatic logic [20:0] raw();
    return {word_valid, done, busy, timeout, err, word_data};
  endfunction

  // Sample j of lane i sits at bit 6i+5-j
  function automatic logic [47:0] mk_dq(input logic [7:0] s0, s1, s2, s3, s4, s5);
    logic [7:0] s [6];
    logic [47:0] v;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4; s[5] = s5;
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 6; j++)
        v[6*i+5-j] = s[j][i];
    return v;
  endfunction

  task automatic cyc(input logic [5:0] rw, input logic [7:0] s0, s1, s2, s3, s4, s5);
    rwds_samples = rw;
    dq_samples   = mk_dq(s0, s1, s2, s3, s4, s5);
    @(posedge iserdes_clkdiv);
    #1;
  endtask

  task automatic test_reset;
    arst = 1'b1;
    #7;
    e = '0; n_chk++;
    if (raw() !== e) begin n_fail++; $display("FAIL rst_outputs: got %h want %h", raw(), e); end
    #1 arst = 1'b0;
    cyc(6'b000000, F, F, F, F, F, F);
    e = ex(5'b00000, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL rst_idle: got %h want %h", obs(), e); end
  endtask

  task automatic test_basic;
    start = 1'b1; rd_len = 16'd4;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    e = ex(5'b00100, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_busy: got %h want %h", obs(), e); end
    cyc(6'b000111, F, F, F, F, 8'hA1, F);
    e = ex(5'b00100, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_first_beat: got %h want %h", obs(), e); end
    cyc(6'b000111, F, 8'hB2, F, F, 8'hC3, F);
    e = ex(5'b10100, 16'hA1B2); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_word0: got %h want %h", obs(), e); end
    cyc(6'b000111, F, 8'hD4, F, F, 8'hE5, F);
    e = ex(5'b10100, 16'hC3D4); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_word1: got %h want %h", obs(), e); end
    cyc(6'b000111, F, 8'hF6, F, F, 8'h07, F);
    e = ex(5'b10100, 16'hE5F6); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_word2: got %h want %h", obs(), e); end
    cyc(6'b000111, F, 8'h18, F, F, F, F);
    e = ex(5'b11000, 16'h0718); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_word3_done: got %h want %h", obs(), e); end
    cyc(6'b000111, F, 8'h29, F, F, 8'h3A, F);
    e = ex(5'b00000, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t1_after_done: got %h want %h", obs(), e); end
  endtask

  task automatic test_carry;
    start = 1'b1; rd_len = 16'd2;
    cyc(6'b111111, F, F, F, F, F, F);
    start = 1'b0;
    cyc(6'b000000, F, F, F, F, F, F);
    e = ex(5'b00100, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t2_preamble: got %h want %h", obs(), e); end
    cyc(6'b000000, F, F, F, F, F, F);
    cyc(6'b000000, F, F, F, F, F, F);
    cyc(6'b001110, F, F, F, 8'h3C, F, F);
    e = ex(5'b00100, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t2_first_rise: got %h want %h", obs(), e); end
    cyc(6'b001110, 8'h4D, F, F, 8'h5E, F, F);
    e = ex(5'b10100, 16'h3C4D); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t2_carry_word: got %h want %h", obs(), e); end
    cyc(6'b001110, 8'h6F, F, F, F, F, F);
    e = ex(5'b11000, 16'h5E6F); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t2_carry_done: got %h want %h", obs(), e); end
  endtask

  task automatic test_timeout;
    start = 1'b1; rd_len = 16'd2;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    for (int n = 1; n <= TO + 1; n++) begin
      cyc(6'b000000, F, F, F, F, F, F);
      if (n < TO)       e = ex(5'b00100, 16'h0);
      else if (n == TO) e = ex(5'b00010, 16'h0);
      else              e = ex(5'b00000, 16'h0);
      n_chk++;
      if (obs() !== e) begin n_fail++; $display("FAIL t3_cycle%0d: got %h want %h", n, obs(), e); end
    end
  endtask

  task automatic test_overflow;
    start = 1'b1; rd_len = 16'd2;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    cyc(6'b000111, F, F, F, F, 8'h5A, F);
    cyc(6'b010101, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    e = ex(5'b10101, 16'h5A22); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t4_err_set: got %h want %h", obs(), e); end
    cyc(6'b111000, 8'h77, F, F, F, 8'h88, F);
`ifdef HBMC_DQ_CAPTURE_GLITCH_CHECK_EN
    e = ex(5'b00101, 16'h0);
`else
    e = ex(5'b11001, 16'h3377);
`endif
    n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t4_after_drop: got %h want %h", obs(), e); end
    for (int i = 0; i < 40 && busy; i++) cyc(6'b000000, F, F, F, F, F, F);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_idle_wait: got busy=%b want 0", busy); end
    start = 1'b1; rd_len = 16'd1;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    e = ex(5'b00100, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t4_err_clear: got %h want %h", obs(), e); end
    cyc(6'b000111, F, F, F, F, 8'h9C, F);
    cyc(6'b000111, F, 8'hD3, F, F, F, F);
    e = ex(5'b11000, 16'h9CD3); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t4_clean_word: got %h want %h", obs(), e); end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; rd_len = 16'd3;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    cyc(6'b000111, F, F, F, F, 8'h12, F);
    cyc(6'b000111, F, 8'h34, F, F, 8'h56, F);
    e = ex(5'b10100, 16'h1234); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t5_word0: got %h want %h", obs(), e); end
    #2 arst = 1'b1;
    #1;
    e = '0; n_chk++;
    if (raw() !== e) begin n_fail++; $display("FAIL t5_async_clear: got %h want %h", raw(), e); end
    @(posedge iserdes_clkdiv);
    #1 arst = 1'b0;
    cyc(6'b000000, F, F, F, F, F, F);
    e = ex(5'b00000, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t5_no_pulse: got %h want %h", obs(), e); end
    start = 1'b1; rd_len = 16'd1;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    cyc(6'b000111, F, F, F, F, 8'hAB, F);
    cyc(6'b000111, F, 8'hCD, F, F, F, F);
    e = ex(5'b11000, 16'hABCD); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t5_clean_word: got %h want %h", obs(), e); end
  endtask

  task automatic test_zero_len;
    start = 1'b1; rd_len = 16'd0;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    e = ex(5'b01000, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t6_zero_done: got %h want %h", obs(), e); end
    cyc(6'b000000, F, F, F, F, F, F);
    e = ex(5'b00000, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t6_zero_pulse: got %h want %h", obs(), e); end
    start = 1'b1; rd_len = 16'd1;
    cyc(6'b000000, F, F, F, F, F, F);
    rd_len = 16'd5;
    cyc(6'b000000, F, F, F, F, F, F);
    start = 1'b0;
    e = ex(5'b00100, 16'h0); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t6_start_busy: got %h want %h", obs(), e); end
    cyc(6'b000111, F, F, F, F, 8'hE1, F);
    cyc(6'b000111, F, 8'hF2, F, F, F, F);
    e = ex(5'b11000, 16'hE1F2); n_chk++;
    if (obs() !== e) begin n_fail++; $display("FAIL t6_len_kept: got %h want %h", obs(), e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_zero_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
